// File: rtl/bmem_responder.sv
// bmem_responder: burst-memory endpoint for the cacheline adapter.
// Lines are 256 bits moved as four 64-bit beats; reads return in order
// after READ_LATENCY cycles, writes commit the whole line on beat3.
module bmem_responder #(
    parameter int unsigned MEM_LINES    = 256,
    parameter int unsigned READ_LATENCY = 8,
    parameter int unsigned QUEUE_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid
);

    localparam int unsigned IDX_W   = $clog2(MEM_LINES);
    localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
    localparam logic [31:0] LATENCY = 32'(READ_LATENCY);

    typedef enum logic {
        W_IDLE,
        W_BURST
    } wstate_t;

    wstate_t wstate;
    wstate_t wstate_next;

    // Backing store, not cleared by reset
    logic [255:0] mem [MEM_LINES];

    // Free-running stamp source; age is taken modulo 2^32
    logic [31:0] cycle_cnt;

    // Read queue: line address and acceptance stamp per entry
    logic [26:0]      q_line  [QUEUE_DEPTH];
    logic [31:0]      q_stamp [QUEUE_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] head;
    logic             q_empty;
    logic             q_full;

    // Streamer
    logic             busy;
    logic [1:0]       beat;
    logic             head_ready;
    logic             issue;
    logic [IDX_W-1:0] head_idx;
    logic [7:0]       roff;

    // Write collection
    logic [1:0]       wcount;
    logic [191:0]     wbuf;
    logic [IDX_W-1:0] widx;
    logic [7:0]       woff;

    logic read_accept;
    logic write_start;
    logic write_beat;
    logic write_commit;

    logic unused_addr_bits;
    assign unused_addr_bits = ^bmem_addr[4:0];

    assign head     = rd_ptr[PTR_W-1:0];
    assign q_empty  = (wr_ptr == rd_ptr);
    assign q_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_idx = q_line[head][IDX_W-1:0];
    // Head stays queued while streaming, so busy implies a valid head
    assign head_ready = !q_empty && ((cycle_cnt - q_stamp[head]) >= LATENCY);
    assign issue      = busy || head_ready;
    assign roff       = {beat, 6'b0};
    assign woff       = {wcount, 6'b0};

    // Cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wstate_next;
        end
    end

    // Write FSM next state, ready and acceptance strobes
    always_comb begin
        wstate_next  = wstate;
        bmem_ready   = 1'b0;
        read_accept  = 1'b0;
        write_start  = 1'b0;
        write_beat   = 1'b0;
        write_commit = 1'b0;
        case (wstate)
            W_IDLE: begin
                // Writes wait for the read side to drain; a simultaneous read is dropped
                if (bmem_write) begin
                    bmem_ready = !rst && q_empty && !busy;
                end else begin
                    bmem_ready = !rst && !q_full;
                end
                if (bmem_ready && bmem_write) begin
                    write_start = 1'b1;
                    wstate_next = W_BURST;
                end else if (bmem_ready && bmem_read) begin
                    read_accept = 1'b1;
                end
            end
            W_BURST: begin
                bmem_ready = !rst;
                if (!rst && bmem_write) begin
                    write_beat = 1'b1;
                    if (wcount == 2'd3) begin
                        write_commit = 1'b1;
                        wstate_next  = W_IDLE;
                    end
                end
            end
            default: wstate_next = W_IDLE;
        endcase
    end

    // Write beat capture; address taken at beat0 only
    always_ff @(posedge clk) begin
        if (rst) begin
            wcount <= '0;
        end else if (write_start) begin
            wcount      <= 2'd1;
            widx        <= bmem_addr[5 +: IDX_W];
            wbuf[63:0]  <= bmem_wdata;
        end else if (write_beat) begin
            wcount <= wcount + 2'd1;
            if (wcount != 2'd3) begin
                wbuf[woff +: 64] <= bmem_wdata;
            end
        end
    end

    // Line commit on beat3, beat3 taken straight from the bus
    always_ff @(posedge clk) begin
        if (write_commit) begin
            mem[widx] <= {bmem_wdata, wbuf};
        end
    end

    // Read queue entry storage
    always_ff @(posedge clk) begin
        if (read_accept) begin
            q_line[wr_ptr[PTR_W-1:0]]  <= bmem_addr[31:5];
            q_stamp[wr_ptr[PTR_W-1:0]] <= cycle_cnt;
        end
    end

    // Queue pointers and registered beat streaming
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            busy        <= 1'b0;
            beat        <= '0;
            bmem_rvalid <= 1'b0;
            bmem_rdata  <= '0;
            bmem_raddr  <= '0;
        end else begin
            if (read_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            bmem_rvalid <= issue;
            if (issue) begin
                bmem_rdata <= mem[head_idx][roff +: 64];
                bmem_raddr <= {q_line[head], 5'b0};
                beat       <= beat + 2'd1;
                busy       <= (beat != 2'd3);
                if (beat == 2'd3) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Read and write in the same cycle is a protocol error on the requester side
    rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(bmem_read && bmem_write));

endmodule
